mem_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS datapath. Detects load-use

---
 rtl/mem_hazard_ctrl.sv | 93 +++++++++
 tb/tb_mem_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_hazard_ctrl.sv
// Pipeline sequencing: load-use interlock in ID plus req/ack handshake for the EX/MEM data access.
// Mem stall lasts 1 + ACCESS cycles and beats load-use; a missing ack aborts after TIMEOUT cycles.
module mem_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_ack,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_op;
  logic             mem_stall;
  logic             load_use;
  logic             wait_last;

  assign mem_op    = mem_read | mem_write;
  assign mem_stall = ((state == IDLE) && mem_op) || (state == ACCESS);
  assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign wait_last = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // The memory stall freezes everything up to EX/MEM, so it must win over the load-use bubble.
  assign pc_write     = !(mem_stall || load_use);
  assign ifid_write   = !(mem_stall || load_use);
  assign idex_write   = !mem_stall;
  assign idex_bubble  = load_use && !mem_stall;
  assign exmem_hold   = mem_stall;
  assign memwb_bubble = mem_stall || (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      stall_count <= '0;
      timeout_err <= 1'b0;
      dmem_req    <= 1'b0;
    end else begin
      if ((mem_stall || load_use) && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;

      case (state)
        IDLE: begin
          if (mem_op) begin
            state    <= ACCESS;
            wait_cnt <= '0;
            dmem_req <= 1'b1;
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          // An ack arriving on the final allowed cycle still completes the access.
          if (mem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
          end else if (wait_last) begin
            state    <= ERR;
            dmem_req <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          timeout_err <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_hazard_ctrl.sv
// Bench for mem_hazard_ctrl: directed scenarios with literal expectations, then random traffic vs a model.
module tb_mem_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_mem_read = 0, mem_read = 0, mem_write = 0, mem_ack = 0;
  logic dmem_req, pc_write, ifid_write, idex_write, idex_bubble, exmem_hold, memwb_bubble;
  logic [CW-1:0] stall_count;
  logic timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ack(mem_ack), .dmem_req(dmem_req), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble),
    .stall_count(stall_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is "busy" for some number of cycles, then leaves one post cycle (done or error).
  bit m_busy;
  int m_age;
  int m_post;   // 0 none, 1 completed, 2 aborted
  bit m_err;
  int m_cnt;

  function automatic bit f_lu();
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  function automatic bit f_ms();
    return m_busy || (!m_busy && m_post == 0 && (mem_read || mem_write));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_age <= 0; m_post <= 0; m_err <= 0; m_cnt <= 0;
    end else begin
      if (f_ms() || f_lu()) m_cnt <= (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      if (m_busy) begin
        if (mem_ack) begin m_busy <= 0; m_post <= 1; end
        else if (m_age + 1 == TO) begin m_busy <= 0; m_post <= 2; end
        m_age <= m_age + 1;
      end else if (m_post != 0) begin
        if (m_post == 2) m_err <= 1;
        m_post <= 0;
      end else if (mem_read || mem_write) begin
        m_busy <= 1; m_age <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("dmem_req",     32'(dmem_req),     32'(m_busy));
      chk("pc_write",     32'(pc_write),     32'(!(f_ms() || f_lu())));
      chk("ifid_write",   32'(ifid_write),   32'(!(f_ms() || f_lu())));
      chk("idex_write",   32'(idex_write),   32'(!f_ms()));
      chk("idex_bubble",  32'(idex_bubble),  32'(f_lu() && !f_ms()));
      chk("exmem_hold",   32'(exmem_hold),   32'(f_ms()));
      chk("memwb_bubble", 32'(memwb_bubble), 32'(f_ms() || m_post == 2));
      chk("stall_count",  32'(stall_count),  32'(m_cnt));
      chk("timeout_err",  32'(timeout_err),  32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_in();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0;
    mem_read = 0; mem_write = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    zero_in();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
    chk("rst_pc_write", 32'(pc_write), 1);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
  endtask

  initial begin
    do_reset();

    // Load-use hit, then the same with $zero as destination.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; #1;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_idex_bubble", 32'(idex_bubble), 1);
    chk("lu_idex_write", 32'(idex_write), 1);
    step();
    ex_rt = 0; id_rs = 0; #1;
    chk("lu0_pc_write", 32'(pc_write), 1);
    step(); #1;
    chk("lu0_stall_count", 32'(stall_count), 1);
    zero_in();

    // Load with ack on the third ACCESS cycle.
    do_reset();
    mem_read = 1; step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ack = 1;
      #1 chk("acc_dmem_req", 32'(dmem_req), 1);
      step();
    end
    mem_read = 0; mem_ack = 0; #1;
    chk("done_dmem_req", 32'(dmem_req), 0);
    chk("done_pc_write", 32'(pc_write), 1);
    chk("done_memwb_bubble", 32'(memwb_bubble), 0);
    step(); #1;
    chk("acc_stall_count", 32'(stall_count), 4);
    chk("acc_timeout_err", 32'(timeout_err), 0);

    // Store with no ack aborts after TIMEOUT ACCESS cycles; error is sticky.
    mem_write = 1; step();
    for (int i = 0; i < TO; i++) step();
    mem_write = 0; #1;
    chk("err_memwb_bubble", 32'(memwb_bubble), 1);
    chk("err_dmem_req", 32'(dmem_req), 0);
    step(); #1;
    chk("err_timeout_err", 32'(timeout_err), 1);
    mem_read = 1; step();
    mem_ack = 1; step();
    mem_read = 0; mem_ack = 0; step(); #1;
    chk("err_sticky", 32'(timeout_err), 1);

    // Ack on the last allowed ACCESS cycle wins over the abort.
    do_reset();
    mem_read = 1; step();
    for (int i = 0; i < TO - 1; i++) step();
    mem_ack = 1; step();
    mem_read = 0; mem_ack = 0; #1;
    chk("late_ack_bubble", 32'(memwb_bubble), 0);
    step(); #1;
    chk("late_ack_err", 32'(timeout_err), 0);

    // Reset in the middle of an access clears everything at once.
    mem_read = 1; step(); step();
    zero_in(); rst = 1; #1;
    chk("arst_dmem_req", 32'(dmem_req), 0);
    chk("arst_stall_count", 32'(stall_count), 0);
    chk("arst_exmem_hold", 32'(exmem_hold), 0);
    chk("arst_pc_write", 32'(pc_write), 1);
    #1 rst = 0;
    step();

    // Memory stall and load-use together, then load-use alone after DONE.
    mem_read = 1; ex_mem_read = 1; ex_rt = 7; id_rt = 7; #1;
    chk("both_idex_bubble", 32'(idex_bubble), 0);
    chk("both_idex_write", 32'(idex_write), 0);
    chk("both_exmem_hold", 32'(exmem_hold), 1);
    step();
    mem_ack = 1; step();
    mem_read = 0; mem_ack = 0; #1;
    chk("after_idex_bubble", 32'(idex_bubble), 1);
    step();
    zero_in(); #1;
    chk("clear_idex_bubble", 32'(idex_bubble), 0);

    // Random traffic; the negedge compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      ex_mem_read = ($urandom_range(0, 1) == 1);
      mem_read    = ($urandom_range(0, 3) == 0);
      mem_write   = ($urandom_range(0, 5) == 0);
      mem_ack     = ($urandom_range(0, 2) == 0);
      if (c > 1000 && $urandom_range(0, 399) == 0) begin
        rst = 1; #1 rst = 0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
